// File: rtl/ahb_lite_req_arbiter_pkg.sv
// Shared AHB-Lite codes and sizing helpers for the requester arbiter.
package ahb_lite_req_arbiter_pkg;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  localparam int ARB_NREQ_MAX = 8;

  // Pointer width for an n-way round robin; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ahb_rr_arbiter.sv
// Combinational round-robin picker: first request at or after i_ptr, wrapping.
module ahb_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [PW-1:0]     w_off;
  logic [PW:0]       w_sum;

  // Rotate so that bit 0 is the requester the pointer names.
  assign w_dbl = {i_req, i_req};
  assign w_rot = NREQ'(w_dbl >> i_ptr);

  always_comb begin
    w_off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = PW'(k);
    end
  end

  assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx   = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : w_sum[PW-1:0];
  assign o_any   = |i_req;
  assign o_grant = o_any ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/ahb_lite_req_arbiter.sv
// Shares one AHB-Lite master among NREQ requesters: round-robin grant,
// address/data pipeline tracking, error parking and response routing.
module ahb_lite_req_arbiter
  import ahb_lite_req_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ*3-1:0]  req_size,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err,
  output logic             m_write,
  output logic [AW-1:0]    m_addr,
  output logic [DW-1:0]    m_data,
  output logic [2:0]       m_size,
  output logic             m_idle,
  input  logic             HREADY,
  input  logic             HRESP,
  input  logic [DW-1:0]    HRDATA
);

  localparam int PW = ptr_width(NREQ);

  logic [AW-1:0] w_addr_arr [NREQ];
  logic [DW-1:0] w_data_arr [NREQ];
  logic [2:0]    w_size_arr [NREQ];

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_win;
  logic [PW-1:0]   w_ptr_next;
  logic            w_any;
  logic            w_can_grant;
  logic            w_take;

  logic            r_a_vld;
  logic [PW-1:0]   r_a_own;
  logic            r_d_vld;
  logic [PW-1:0]   r_d_own;
  logic [PW-1:0]   r_rr_ptr;
  logic            r_park;
  logic            r_write;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_data;
  logic [2:0]      r_size;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_addr_arr[gi] = req_addr[gi*AW +: AW];
      assign w_data_arr[gi] = req_wdata[gi*DW +: DW];
      assign w_size_arr[gi] = req_size[gi*3 +: 3];
      assign rsp_valid[gi]  = r_d_vld & HREADY & (r_d_own == PW'(gi));
    end
  endgenerate

  ahb_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win),
    .o_any   (w_any)
  );

  // A parked command must go back on the bus before anyone new is accepted.
  assign w_can_grant = HREADY & ~r_park & ~HRESET;
  assign w_take      = w_any & w_can_grant;
  assign req_ready   = w_can_grant ? w_grant : '0;
  assign w_ptr_next  = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_a_vld  <= 1'b0;
      r_a_own  <= '0;
      r_d_vld  <= 1'b0;
      r_d_own  <= '0;
      r_rr_ptr <= '0;
      r_park   <= 1'b0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
      r_size   <= HSIZE_WORD;
    end else if (HREADY) begin
      if (r_park) begin
        // Second error cycle: the failed data phase retires, A stays put.
        r_d_vld <= 1'b0;
        r_park  <= 1'b0;
      end else begin
        r_d_vld <= r_a_vld;
        r_d_own <= r_a_own;
        r_a_vld <= w_take;
        if (w_take) begin
          r_a_own  <= w_win;
          r_write  <= req_write[w_win];
          r_addr   <= w_addr_arr[w_win];
          r_data   <= w_data_arr[w_win];
          r_size   <= w_size_arr[w_win];
          r_rr_ptr <= w_ptr_next;
        end
      end
    end else if (HRESP == HRESP_ERROR) begin
      r_park <= 1'b1;
    end
  end

  assign m_idle    = ~r_a_vld | r_park;
  assign m_write   = r_write;
  assign m_addr    = r_addr;
  assign m_data    = r_data;
  assign m_size    = r_size;
  assign rsp_rdata = HRDATA;
  assign rsp_err   = HRESP;

endmodule

// File: tb/tb_ahb_lite_req_arbiter.sv
// Directed bench for ahb_lite_req_arbiter with hand-computed expectations.
module tb_ahb_lite_req_arbiter;
  import ahb_lite_req_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic              HCLK = 1'b0;
  logic              HRESET = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_write = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ*3-1:0]  req_size = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              m_write;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_data;
  logic [2:0]        m_size;
  logic              m_idle;
  logic              HREADY = 1'b1;
  logic              HRESP = 1'b0;
  logic [DW-1:0]     HRDATA = '0;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0]  T2_RDY  [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0};
  localparam logic [31:0] T2_ADDR [8] = '{32'h0, 32'h1000, 32'h1010, 32'h1020, 32'h1030,
                                          32'h1000, 32'h1000, 32'h1000};
  localparam logic        T2_IDLE [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [3:0]  T2_RSP  [8] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0};

  ahb_lite_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .m_write   (m_write),
    .m_addr    (m_addr),
    .m_data    (m_data),
    .m_size    (m_size),
    .m_idle    (m_idle),
    .HREADY    (HREADY),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] s);
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_size[i*3 +: 3] = s;
    $display("req%0d %s addr=%08h data=%08h size=%0d", i, w ? "WR" : "RD", a, d, s);
    if (s > HSIZE_WORD) $display("note: req%0d uses unsupported HSIZE %0d (misuse)", i, s);
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(); tick();
    HRDATA = 32'h1234;
    settle();
    chk("rst_idle", m_idle, 1);
    chk("rst_write", m_write, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_data", m_data, 0);
    chk("rst_size", m_size, HSIZE_WORD);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 32'h1234);
    tick();
    HRESET = 1'b0;
    HRDATA = '0;

    // 1. single write
    set_req(0, 1'b1, 32'hAABB, 32'hAABB, HSIZE_WORD);
    settle();
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    clr_req(0);
    settle();
    chk("t1_addr", m_addr, 32'hAABB);
    chk("t1_idle", m_idle, 0);
    chk("t1_write", m_write, 1);
    chk("t1_data", m_data, 32'hAABB);
    chk("t1_norsp", rsp_valid, 0);
    tick();
    settle();
    chk("t1_rsp", rsp_valid, 4'b0001);
    chk("t1_err", rsp_err, 0);
    chk("t1_idle2", m_idle, 1);
    tick();

    // 2. round robin from a fresh pointer
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 32'h1000 + 32'(i) * 32'h10, 32'h0, HSIZE_WORD);
    for (int c = 0; c < 8; c++) begin
      if (c == 5) req_valid = '0;
      settle();
      chk($sformatf("t2_ready[%0d]", c), req_ready, T2_RDY[c]);
      chk($sformatf("t2_addr[%0d]", c), m_addr, T2_ADDR[c]);
      chk($sformatf("t2_idle[%0d]", c), m_idle, T2_IDLE[c]);
      chk($sformatf("t2_rsp[%0d]", c), rsp_valid, T2_RSP[c]);
      tick();
    end

    // 3. read with two wait states; pointer is now 1
    set_req(1, 1'b0, 32'hBF00, 32'h0, HSIZE_WORD);
    settle();
    chk("t3_ready", req_ready, 4'b0010);
    tick();
    clr_req(1);
    settle();
    chk("t3_addr", m_addr, 32'hBF00);
    chk("t3_idle", m_idle, 0);
    tick();
    HREADY = 1'b0;
    set_req(3, 1'b1, 32'h3300, 32'h33, HSIZE_WORD);
    settle();
    chk("t3_w1_rsp", rsp_valid, 0);
    chk("t3_w1_ready", req_ready, 0);
    chk("t3_w1_addr", m_addr, 32'hBF00);
    chk("t3_w1_write", m_write, 0);
    tick();
    settle();
    chk("t3_w2_rsp", rsp_valid, 0);
    chk("t3_w2_ready", req_ready, 0);
    chk("t3_w2_addr", m_addr, 32'hBF00);
    tick();
    HREADY = 1'b1;
    HRDATA = 32'hBF00;
    settle();
    chk("t3_rsp", rsp_valid, 4'b0010);
    chk("t3_rdata", rsp_rdata, 32'hBF00);
    chk("t3_err", rsp_err, 0);
    chk("t3_ready3", req_ready, 4'b1000);
    tick();
    clr_req(3);
    HRDATA = '0;
    settle();
    chk("t3_addr3", m_addr, 32'h3300);
    chk("t3_data3", m_data, 32'h33);
    chk("t3_norsp", rsp_valid, 0);
    tick();
    settle();
    chk("t3_rsp3", rsp_valid, 4'b1000);
    tick();

    // 4. two-cycle error with parked read; pointer is now 0
    set_req(0, 1'b1, 32'h9999, 32'h5555, HSIZE_WORD);
    settle();
    chk("t4_ready0", req_ready, 4'b0001);
    tick();
    clr_req(0);
    set_req(2, 1'b0, 32'hACAC, 32'h0, HSIZE_WORD);
    settle();
    chk("t4_ready2", req_ready, 4'b0100);
    chk("t4_addr0", m_addr, 32'h9999);
    tick();
    clr_req(2);
    HRESP = 1'b1;
    HREADY = 1'b0;
    settle();
    chk("t4_e1_addr", m_addr, 32'hACAC);
    chk("t4_e1_idle", m_idle, 0);
    chk("t4_e1_rsp", rsp_valid, 0);
    tick();
    HREADY = 1'b1;
    set_req(1, 1'b1, 32'h1111, 32'h11, HSIZE_WORD);
    settle();
    chk("t4_e2_idle", m_idle, 1);
    chk("t4_e2_rsp", rsp_valid, 4'b0001);
    chk("t4_e2_err", rsp_err, 1);
    chk("t4_e2_ready", req_ready, 0);
    tick();
    HRESP = 1'b0;
    settle();
    chk("t4_re_idle", m_idle, 0);
    chk("t4_re_addr", m_addr, 32'hACAC);
    chk("t4_re_ready", req_ready, 4'b0010);
    chk("t4_re_rsp", rsp_valid, 0);
    tick();
    clr_req(1);
    settle();
    chk("t4_rsp2", rsp_valid, 4'b0100);
    chk("t4_rsp2_err", rsp_err, 0);
    chk("t4_addr1", m_addr, 32'h1111);
    tick();
    settle();
    chk("t4_rsp1", rsp_valid, 4'b0010);
    tick();

    // 5. reset with both slots full; pointer is now 2
    set_req(3, 1'b0, 32'h3000, 32'h0, HSIZE_WORD);
    settle();
    chk("t5_ready3", req_ready, 4'b1000);
    tick();
    clr_req(3);
    set_req(1, 1'b0, 32'h1A00, 32'h0, HSIZE_WORD);
    settle();
    chk("t5_ready1", req_ready, 4'b0010);
    tick();
    clr_req(1);
    settle();
    chk("t5_full_idle", m_idle, 0);
    chk("t5_full_addr", m_addr, 32'h1A00);
    HRESET = 1'b1;
    set_req(1, 1'b0, 32'h1A00, 32'h0, HSIZE_WORD);
    set_req(2, 1'b0, 32'h2A00, 32'h0, HSIZE_WORD);
    settle();
    chk("t5_rst_idle", m_idle, 1);
    chk("t5_rst_rsp", rsp_valid, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_addr", m_addr, 0);
    tick();
    settle();
    chk("t5_rst_rsp2", rsp_valid, 0);
    HRESET = 1'b0;
    settle();
    chk("t5_after_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    settle();
    chk("t5_after_addr", m_addr, 32'h1A00);
    chk("t5_after_norsp", rsp_valid, 0);
    tick();
    settle();
    chk("t5_after_rsp", rsp_valid, 4'b0010);
    tick();

    // Unsupported size is forwarded untouched; pointer is now 2
    set_req(2, 1'b1, 32'h2200, 32'h22, 3'b011);
    settle();
    chk("tm_ready", req_ready, 4'b0100);
    tick();
    clr_req(2);
    settle();
    chk("tm_size", m_size, 3'b011);
    tick();
    tick();

    // 6. idle bus
    for (int c = 0; c < 5; c++) begin
      settle();
      chk($sformatf("t6_idle[%0d]", c), m_idle, 1);
      chk($sformatf("t6_ready[%0d]", c), req_ready, 0);
      chk($sformatf("t6_rsp[%0d]", c), rsp_valid, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
